// File: rtl/hub75_slice_sequencer.sv
// HUB75 panel scan sequencer: for each theta slice, fetches and shifts every
// pixel of every scan row, then blanks, latches and shows that row.
`timescale 1ns/1ps

module hub75_slice_sequencer #(
  parameter int NUM_COLS    = 64,
  parameter int SCAN_RATE   = 32,
  parameter int SHOW_CYCLES = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         slice_start,
  output logic                         pix_req,
  output logic [$clog2(SCAN_RATE)-1:0] pix_row,
  output logic [$clog2(NUM_COLS)-1:0]  pix_col,
  input  logic                         pix_valid,
  input  logic [2:0]                   pix_rgb0,
  input  logic [2:0]                   pix_rgb1,
  output logic [$clog2(SCAN_RATE)-1:0] hub75_addr,
  output logic [2:0]                   hub75_rgb0,
  output logic [2:0]                   hub75_rgb1,
  output logic                         hub75_clk,
  output logic                         hub75_latch,
  output logic                         hub75_OE,
  output logic                         busy,
  output logic                         overrun
);

  localparam int RW = $clog2(SCAN_RATE);
  localparam int CW = $clog2(NUM_COLS);
  localparam int SW = $clog2(SHOW_CYCLES + 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(SCAN_RATE - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(NUM_COLS - 1);
  localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, CLK_LO, CLK_HI, BLANK, LATCH, SHOW
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [SW-1:0] show_q, show_d;
  logic          overrun_d;

  logic [RW-1:0] addr_q;
  logic [2:0]    rgb0_q, rgb1_q;
  logic          oe_q, latch_q, clk_q, req_q, busy_q, overrun_q;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    show_d    = show_q;
    overrun_d = slice_start && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (slice_start) begin
          row_d   = '0;
          col_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (pix_valid) state_d = CLK_LO;
      end
      CLK_LO: state_d = CLK_HI;
      CLK_HI: begin
        if (col_q == COL_LAST) begin
          col_d   = '0;
          state_d = BLANK;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = FETCH;
        end
      end
      BLANK: state_d = LATCH;
      LATCH: begin
        show_d  = '0;
        state_d = SHOW;
      end
      SHOW: begin
        if (show_q == SHOW_LAST) begin
          show_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = FETCH;
          end
        end else begin
          show_d = show_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Panel strobes are decoded from the next state so every output is a flop
  // that lines up exactly with the state it belongs to.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      show_q    <= '0;
      addr_q    <= '0;
      rgb0_q    <= '0;
      rgb1_q    <= '0;
      oe_q      <= 1'b1;
      latch_q   <= 1'b0;
      clk_q     <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      show_q    <= show_d;
      oe_q      <= (state_d != SHOW);
      latch_q   <= (state_d == LATCH);
      clk_q     <= (state_d == CLK_HI);
      req_q     <= (state_d == FETCH);
      busy_q    <= (state_d != IDLE);
      overrun_q <= overrun_d;
      if (state_d == LATCH) addr_q <= row_q;
      if (state_q == FETCH && pix_valid) begin
        rgb0_q <= pix_rgb0;
        rgb1_q <= pix_rgb1;
      end
    end
  end

  assign pix_req     = req_q;
  assign pix_row     = row_q;
  assign pix_col     = col_q;
  assign hub75_addr  = addr_q;
  assign hub75_rgb0  = rgb0_q;
  assign hub75_rgb1  = rgb1_q;
  assign hub75_clk   = clk_q;
  assign hub75_latch = latch_q;
  assign hub75_OE    = oe_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_hub75_slice_sequencer.sv
// Directed bench for hub75_slice_sequencer with a 4-column, 2-row, 3-cycle-show
// configuration; expected values are worked out by hand from the slice timing.
`timescale 1ns/1ps

module tb_hub75_slice_sequencer;

  logic       clk = 1'b0;
  logic       rstN;
  logic       sliceStart;
  logic       pixReq;
  logic [0:0] pixRow;
  logic [1:0] pixCol;
  logic       pixValid;
  logic [2:0] pixRgb0, pixRgb1;
  logic [0:0] hub75Addr;
  logic [2:0] hub75Rgb0, hub75Rgb1;
  logic       hub75Clk, hub75Latch, hub75Oe, busy, overrun;

  logic       delayEnable;
  int         reqRun;

  int checkCount = 0;
  int passCount  = 0;

  int clkRises = 0, latchCount = 0, oeLowCycles = 0, busyCycles = 0;
  int overrunCount = 0, violations = 0, clkDuringFetch = 0;
  int runAt02 = 0, lastRunAt02 = 0;
  int rgbLog[64];
  int rgbIdx = 0;
  int latchLog[32];
  int latchIdx = 0;
  logic prevClk = 1'b0;
  logic prevOe = 1'b1;
  logic [0:0] prevAddr = '0;

  int baseClk, baseLatch, baseOe, baseBusy, baseOverrun, baseRgb, baseLatchIdx;

  hub75_slice_sequencer #(
    .NUM_COLS(4),
    .SCAN_RATE(2),
    .SHOW_CYCLES(3)
  ) dut (
    .clk_in(clk),
    .rst_in(rstN),
    .slice_start(sliceStart),
    .pix_req(pixReq),
    .pix_row(pixRow),
    .pix_col(pixCol),
    .pix_valid(pixValid),
    .pix_rgb0(pixRgb0),
    .pix_rgb1(pixRgb1),
    .hub75_addr(hub75Addr),
    .hub75_rgb0(hub75Rgb0),
    .hub75_rgb1(hub75Rgb1),
    .hub75_clk(hub75Clk),
    .hub75_latch(hub75Latch),
    .hub75_OE(hub75Oe),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // The pixel source answers with the column number on the top half and its
  // complement on the bottom half; optionally it stalls twice at row 0, col 2.
  assign pixRgb0  = {1'b0, pixCol};
  assign pixRgb1  = ~{1'b0, pixCol};
  assign pixValid = !(delayEnable && pixReq && pixRow == 1'b0 && pixCol == 2'd2 && reqRun < 2);

  always @(posedge clk) begin
    if (pixReq && pixRow == 1'b0 && pixCol == 2'd2) reqRun <= reqRun + 1;
    else reqRun <= 0;
  end

  // Mid-cycle monitor: tallies panel activity and watches the latch/address
  // rules that must hold while the panel is lit.
  always @(negedge clk) begin
    if (hub75Clk && !prevClk) begin
      if (rgbIdx < 64) rgbLog[rgbIdx] = int'(hub75Rgb0) * 8 + int'(hub75Rgb1);
      rgbIdx++;
      clkRises++;
    end
    if (hub75Latch) begin
      if (latchIdx < 32) latchLog[latchIdx] = int'(hub75Addr);
      latchIdx++;
      latchCount++;
    end
    if (!hub75Oe) oeLowCycles++;
    if (busy) busyCycles++;
    if (overrun) overrunCount++;
    if (hub75Clk && pixReq) clkDuringFetch++;
    if (hub75Latch && !hub75Oe) violations++;
    if (!hub75Oe && !prevOe && hub75Addr != prevAddr) violations++;
    if (pixReq && pixRow == 1'b0 && pixCol == 2'd2) runAt02++;
    else if (runAt02 != 0) begin
      lastRunAt02 = runAt02;
      runAt02 = 0;
    end
    prevClk  = hub75Clk;
    prevOe   = hub75Oe;
    prevAddr = hub75Addr;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic snapshot();
    baseClk      = clkRises;
    baseLatch    = latchCount;
    baseOe       = oeLowCycles;
    baseBusy     = busyCycles;
    baseOverrun  = overrunCount;
    baseRgb      = rgbIdx;
    baseLatchIdx = latchIdx;
  endtask

  // Pulse slice_start once and wait (bounded) for the slice to finish.
  task automatic applyStimulus(input int maxCycles);
    @(negedge clk);
    sliceStart = 1'b1;
    @(negedge clk);
    sliceStart = 1'b0;
    for (int i = 0; i < maxCycles && busy; i++) @(negedge clk);
    #1;
    checkOutput("sliceDone", int'(busy), 0);
  endtask

  task automatic checkFullSlice(input string tag, input int expBusy);
    checkOutput({tag, ".busyCycles"}, busyCycles - baseBusy, expBusy);
    checkOutput({tag, ".clkPulses"}, clkRises - baseClk, 8);
    checkOutput({tag, ".latches"}, latchCount - baseLatch, 2);
    checkOutput({tag, ".oeLow"}, oeLowCycles - baseOe, 6);
    checkOutput({tag, ".addrRow0"}, latchLog[baseLatchIdx], 0);
    checkOutput({tag, ".addrRow1"}, latchLog[baseLatchIdx + 1], 1);
  endtask

  initial begin
    rstN        = 1'b0;
    sliceStart  = 1'b0;
    delayEnable = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst.oe", int'(hub75Oe), 1);
    checkOutput("rst.latch", int'(hub75Latch), 0);
    checkOutput("rst.clk", int'(hub75Clk), 0);
    checkOutput("rst.addr", int'(hub75Addr), 0);
    checkOutput("rst.rgb", int'({hub75Rgb0, hub75Rgb1}), 0);
    checkOutput("rst.pixReq", int'(pixReq), 0);
    checkOutput("rst.busy", int'(busy), 0);
    checkOutput("rst.overrun", int'(overrun), 0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] basic slice with pixel data always valid");
    snapshot();
    applyStimulus(200);
    checkFullSlice("basic", 34);
    checkOutput("basic.overrun", overrunCount - baseOverrun, 0);
    checkOutput("basic.rgbCol0", rgbLog[baseRgb + 0], 7);
    checkOutput("basic.rgbCol1", rgbLog[baseRgb + 1], 14);
    checkOutput("basic.rgbCol2", rgbLog[baseRgb + 2], 21);
    checkOutput("basic.rgbCol3", rgbLog[baseRgb + 3], 28);
    checkOutput("basic.rgbRow1Col3", rgbLog[baseRgb + 7], 28);

    $display("[TB] pixel source stalls two cycles at row 0 column 2");
    delayEnable = 1'b1;
    snapshot();
    applyStimulus(200);
    delayEnable = 1'b0;
    checkFullSlice("stall", 36);
    checkOutput("stall.reqHold", lastRunAt02, 3);
    checkOutput("stall.rgbCol2", rgbLog[baseRgb + 2], 21);

    $display("[TB] extra slice_start pulses while busy");
    snapshot();
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      sliceStart = (k == 0 || k == 5 || k == 34);
      @(negedge clk);
    end
    sliceStart = 1'b0;
    #1;
    checkFullSlice("drop", 34);
    checkOutput("drop.overrun", overrunCount - baseOverrun, 2);
    checkOutput("drop.idleAfter", int'(busy), 0);

    $display("[TB] reset during row 1 shifting");
    @(negedge clk);
    sliceStart = 1'b1;
    @(negedge clk);
    sliceStart = 1'b0;
    for (int i = 0; i < 100 && !(hub75Clk && pixRow == 1'b1); i++) @(negedge clk);
    checkOutput("abort.inRow1ClkHi", int'(hub75Clk && pixRow == 1'b1), 1);
    checkOutput("abort.busyBefore", int'(busy), 1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("abort.oe", int'(hub75Oe), 1);
    checkOutput("abort.clk", int'(hub75Clk), 0);
    checkOutput("abort.busy", int'(busy), 0);
    checkOutput("abort.latch", int'(hub75Latch), 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    snapshot();
    applyStimulus(200);
    checkFullSlice("afterReset", 34);
    checkOutput("afterReset.rgbCol0", rgbLog[baseRgb + 0], 7);

    checkOutput("latchOrAddrWhileLit", violations, 0);
    checkOutput("clkHighDuringFetch", clkDuringFetch, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/hub75_slice_sequencer.md
HUB75_SLICE_SEQUENCER -- requirements
Module: hub75_slice_sequencer

Interface
REQ-001 SHALL have parameter NUM_COLS, default 64: pixels shifted per scan row.
REQ-002 SHALL have parameter SCAN_RATE, default 32: scan rows per slice; each row drives two panel rows (rgb0 and rgb1).
REQ-003 SHALL have parameter SHOW_CYCLES, default 16: cycles OE is enabled per row.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_in, input, 1 bit: asynchronous reset, active-low.
REQ-006 SHALL have port slice_start, input, 1 bit: one-cycle pulse marking a new theta slice.
REQ-007 SHALL have port pix_req, output, 1 bit: pixel fetch request.
REQ-008 SHALL have port pix_row, output, $clog2(SCAN_RATE) bits: requested row.
REQ-009 SHALL have port pix_col, output, $clog2(NUM_COLS) bits: requested column.
REQ-010 SHALL have port pix_valid, input, 1 bit: pixel data valid.
REQ-011 SHALL have port pix_rgb0, input, 3 bits: pixel data, top half.
REQ-012 SHALL have port pix_rgb1, input, 3 bits: pixel data, bottom half.
REQ-013 SHALL have port hub75_addr, output, $clog2(SCAN_RATE) bits: panel row address.
REQ-014 SHALL have port hub75_rgb0, output, 3 bits: panel data, top half.
REQ-015 SHALL have port hub75_rgb1, output, 3 bits: panel data, bottom half.
REQ-016 SHALL have port hub75_clk, output, 1 bit: panel shift clock.
REQ-017 SHALL have port hub75_latch, output, 1 bit: panel latch.
REQ-018 SHALL have port hub75_OE, output, 1 bit: output enable, active-low (1 = blanked).
REQ-019 SHALL have port busy, output, 1 bit: high while not IDLE.
REQ-020 SHALL have port overrun, output, 1 bit: one-cycle pulse when a slice_start is dropped.

Function
REQ-021 SHALL implement the states IDLE, FETCH, CLK_LO, CLK_HI, BLANK, LATCH and SHOW.
REQ-022 IDLE SHALL, on slice_start, clear the row and column counters and go to FETCH; every state other than IDLE SHALL ignore slice_start.
REQ-023 FETCH SHALL hold pix_req=1 with pix_row/pix_col equal to the current counters, stay until pix_valid=1, then capture pix_rgb0/pix_rgb1 into hub75_rgb0/hub75_rgb1 and go to CLK_LO; pix_valid outside FETCH SHALL be ignored.
REQ-024 CLK_LO SHALL last one cycle with hub75_clk=0 and data stable, then go to CLK_HI.
REQ-025 CLK_HI SHALL last one cycle with hub75_clk=1, then go to BLANK and clear the column counter if column==NUM_COLS-1, otherwise increment the column counter and go to FETCH.
REQ-026 BLANK SHALL last one cycle with hub75_OE=1, then go to LATCH.
REQ-027 LATCH SHALL last one cycle with hub75_latch=1 and hub75_addr set to the current row, then go to SHOW.
REQ-028 SHOW SHALL hold hub75_OE=0 for exactly SHOW_CYCLES cycles.
REQ-029 After SHOW, the sequencer SHALL go to IDLE if row==SCAN_RATE-1, otherwise increment the row counter and go to FETCH.
REQ-030 hub75_OE SHALL be 1 in every state except SHOW.
REQ-031 hub75_latch SHALL be 0 except in LATCH.
REQ-032 hub75_clk SHALL be 0 except in CLK_HI.
REQ-033 hub75_addr SHALL change only in LATCH and SHALL hold its value in IDLE.
REQ-034 Row timing SHALL be NUM_COLS*(F+2)+2+SHOW_CYCLES cycles, where F is FETCH cycles per pixel (F≥1).
REQ-035 A slice_start while busy=1, including the final SHOW cycle, SHALL be dropped and SHALL pulse overrun=1 on the next cycle.
REQ-036 All counters SHALL wrap only by the explicit compares above and SHALL never exceed NUM_COLS-1 or SCAN_RATE-1.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 While rst_in=0 the sequencer SHALL be held in IDLE asynchronously, and on release SHALL start in IDLE.
REQ-039 While rst_in=0, all counters SHALL be 0 and the outputs SHALL be: hub75_OE=1, hub75_latch=0, hub75_clk=0, hub75_addr=0, hub75_rgb0/hub75_rgb1=0, pix_req=0, busy=0, overrun=0.
REQ-040 Reset asserted mid-slice SHALL abort the slice immediately with the panel blanked; no partial latch SHALL occur.

Verification (NUM_COLS=4, SCAN_RATE=2, SHOW_CYCLES=3)
REQ-041 pix_valid tied 1, single slice_start -> 4 hub75_clk pulses, 1 latch with addr=0, OE low for 3 cycles, then the same for addr=1; busy high for exactly 2*(4*3+2+3)=34 cycles.
REQ-042 pix_valid delayed 2 cycles on column 2 -> pix_req held 3 cycles at pix_row=0, pix_col=2; hub75_clk stays 0 throughout; the row takes 19 cycles.
REQ-043 Second slice_start 5 cycles after the first, and one on the last SHOW cycle -> both dropped, overrun pulses twice, slice output unchanged.
REQ-044 rst_in driven low during the row-1 CLK_HI -> hub75_OE=1, hub75_clk=0, busy=0 asynchronously; after release, a slice_start yields a full correct slice starting at row 0.
REQ-045 Data pattern pix_rgb0=col[2:0], pix_rgb1=~col[2:0] -> on each hub75_clk rising edge, the panel samples 0/7, 1/6, 2/5, 3/4.
REQ-046 Assertion checks SHALL hold throughout: hub75_latch never high while hub75_OE=0, and hub75_addr never changes while hub75_OE=0.
